if_fetch_buf: RTL and testbench

Instruction-fetch front end that consumes the program counter and returns fetched instructions to decode. It issues `pc_i` to a synchronous instruction memory with 1-cycle read latency, captures each returned word with its PC in a small FIFO, and presents the words to the ID stage over a valid/ready handshake. It closes the loop with the PC register by driving `pc_stall` when buffer space runs out, and it flushes all wrong-path state on `br_ctrl`.

---
 rtl/rv_core_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/if_fetch_buf.sv | 71 +++++++
 tb/tb_if_fetch_buf.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_core_pkg.sv
// rtl/rv_core_pkg.sv - shared core types and constants for the fetch front end
package rv_core_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous entry FIFO with flush and occupancy count
module fetch_fifo
    import rv_core_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    output entry_t        head,
    output logic [CW-1:0] count
);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    // Storage has no reset; only pointers and count qualify its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= push_data;
        end
    end

    // Pointer and occupancy update; flush/reset win over push and pop.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rptr];

endmodule

// File: rtl/if_fetch_buf.sv
// rtl/if_fetch_buf.sv - instruction fetch request stage and decode-side buffer
module if_fetch_buf
    import rv_core_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    input  logic            br_ctrl,
    output logic            pc_stall,
    output logic            imem_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic            req_vld_q;
    logic [XLEN-1:0] req_pc_q;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;
    fetch_entry_t    push_data;
    fetch_entry_t    head;

    // A slot is reserved for every request in flight, so a returning word
    // always has room; the stall depends on registered state only.
    assign pc_stall  = rst & ((count + CW'(req_vld_q)) >= CW'(DEPTH));
    assign imem_en   = rst & ~pc_stall;
    assign imem_addr = pc_i;

    // Track the request issued this cycle; a redirect kills the old-path fetch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_vld_q <= 1'b0;
            req_pc_q  <= '0;
        end else begin
            req_vld_q <= imem_en & ~br_ctrl;
            req_pc_q  <= pc_i;
        end
    end

    assign push            = req_vld_q;
    assign push_data.pc    = req_pc_q;
    assign push_data.instr = imem_rdata;

    assign id_valid = rst & (count != '0);
    assign pop      = id_valid & id_ready;
    assign id_pc    = head.pc;
    assign id_instr = id_valid ? head.instr : NOP_INSTR;

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (br_ctrl),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

endmodule

// File: tb/tb_if_fetch_buf.sv
// tb/tb_if_fetch_buf.sv - scoreboard bench for the fetch buffer
module tb_if_fetch_buf;

    localparam logic [31:0] MASK = 32'hA5A5_0000;

    logic        clk        = 1'b0;
    logic        rst        = 1'b0;
    logic        br_ctrl    = 1'b0;
    logic        id_ready   = 1'b0;
    logic [31:0] br_addr    = 32'h0;
    logic [31:0] pc_i       = 32'h0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] imem_addr;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        pc_stall;
    logic        imem_en;
    logic        id_valid;

    int          vectors = 0;
    int          errors  = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    if_fetch_buf #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_i       (pc_i),
        .br_ctrl    (br_ctrl),
        .pc_stall   (pc_stall),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_pc      (id_pc),
        .id_instr   (id_instr)
    );

    // PC register the block closes the loop with
    always @(posedge clk) begin
        if (!rst)          pc_i <= 32'h0;
        else if (br_ctrl)  pc_i <= br_addr;
        else if (!pc_stall) pc_i <= pc_i + 32'd4;
    end

    // Synchronous instruction memory, one cycle of read latency
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= imem_addr ^ MASK;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; br_ctrl = 1'b0; id_ready = 1'b0;
        repeat (2) @(negedge clk);
        sb.delete();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %b want 0", id_valid); end
        vectors++;
        if (pc_stall !== 1'b0) begin errors++; $display("FAIL reset_pc_stall: got %b want 0", pc_stall); end
        vectors++;
        if (imem_en !== 1'b0) begin errors++; $display("FAIL reset_imem_en: got %b want 0", imem_en); end
    endtask

    task automatic test_stream();
        int cyc;
        logic [31:0] exp;
        do_reset();
        id_ready = 1'b1;
        for (int i = 0; i < 16; i++) sb.push_back(32'(i * 4));
        #1;
        vectors++;
        if (imem_en !== 1'b1 || imem_addr !== 32'h0)
            begin errors++; $display("FAIL stream_first_req: en=%b addr=%h want 1/0", imem_en, imem_addr); end
        cyc = 0;
        while (sb.size() > 0 && cyc < 40) begin
            vectors++;
            if (pc_stall !== 1'b0) begin errors++; $display("FAIL stream_stall: cyc %0d got %b want 0", cyc, pc_stall); end
            vectors++;
            if (id_valid !== 1'(cyc >= 2)) begin errors++; $display("FAIL stream_valid: cyc %0d got %b want %b", cyc, id_valid, cyc >= 2); end
            if (id_valid && id_ready) begin
                vectors++;
                if (sb.size() == 0) begin errors++; $display("FAIL stream_pop: extra id_pc=%h", id_pc); end
                else begin
                    exp = sb.pop_front();
                    if (id_pc !== exp || id_instr !== (exp ^ MASK))
                        begin errors++; $display("FAIL stream_pop: got %h/%h want %h/%h", id_pc, id_instr, exp, exp ^ MASK); end
                end
            end
            @(negedge clk); cyc++;
        end
        vectors++;
        if (sb.size() != 0) begin errors++; $display("FAIL stream_timeout: %0d entries never delivered, want 0", sb.size()); end
    endtask

    task automatic test_fill_stall();
        int cyc;
        logic [31:0] exp;
        do_reset();
        cyc = 0;
        while (cyc <= 8) begin
            vectors++;
            if (pc_stall !== 1'(cyc >= 4)) begin errors++; $display("FAIL fill_stall: cyc %0d got %b want %b", cyc, pc_stall, cyc >= 4); end
            vectors++;
            if (id_valid !== 1'(cyc >= 2)) begin errors++; $display("FAIL fill_valid: cyc %0d got %b want %b", cyc, id_valid, cyc >= 2); end
            if (cyc < 8) begin @(negedge clk); cyc++; end
            else cyc++;
        end
        for (int i = 0; i < 6; i++) sb.push_back(32'(i * 4));
        id_ready = 1'b1;
        cyc = 0;
        while (sb.size() > 0 && cyc < 30) begin
            if (cyc == 1) begin
                vectors++;
                if (pc_stall !== 1'b0) begin errors++; $display("FAIL fill_unstall: got %b want 0", pc_stall); end
            end
            if (id_valid && id_ready) begin
                vectors++;
                exp = sb.pop_front();
                if (id_pc !== exp || id_instr !== (exp ^ MASK))
                    begin errors++; $display("FAIL fill_pop: got %h/%h want %h/%h", id_pc, id_instr, exp, exp ^ MASK); end
            end
            @(negedge clk); cyc++;
        end
        vectors++;
        if (sb.size() != 0) begin errors++; $display("FAIL fill_timeout: %0d entries never delivered, want 0", sb.size()); end
    endtask

    task automatic test_flush_inflight();
        int cyc;
        logic [31:0] exp;
        do_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if (id_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid: got %b want 1", id_valid); end
        br_ctrl = 1'b1; br_addr = 32'h100;
        @(negedge clk);
        br_ctrl = 1'b0;
        vectors++;
        if (imem_addr !== 32'h100) begin errors++; $display("FAIL flush_redirect_addr: got %h want 100", imem_addr); end
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) sb.push_back(32'h100 + 32'(i * 4));
        cyc = 1;
        while (sb.size() > 0 && cyc < 20) begin
            if (cyc <= 3) begin
                vectors++;
                if (id_valid !== 1'(cyc == 3)) begin errors++; $display("FAIL flush_valid: t+%0d got %b want %b", cyc, id_valid, cyc == 3); end
            end
            if (id_valid && id_ready) begin
                vectors++;
                exp = sb.pop_front();
                if (id_pc !== exp || id_instr !== (exp ^ MASK))
                    begin errors++; $display("FAIL flush_pop: got %h/%h want %h/%h", id_pc, id_instr, exp, exp ^ MASK); end
            end
            @(negedge clk); cyc++;
        end
        vectors++;
        if (sb.size() != 0) begin errors++; $display("FAIL flush_timeout: %0d entries never delivered, want 0", sb.size()); end
    endtask

    task automatic test_flush_full();
        int cyc;
        logic [31:0] exp;
        do_reset();
        repeat (6) @(negedge clk);
        vectors++;
        if (pc_stall !== 1'b1) begin errors++; $display("FAIL full_stall: got %b want 1", pc_stall); end
        br_ctrl = 1'b1; br_addr = 32'h100;
        @(negedge clk);
        br_ctrl = 1'b0;
        vectors++;
        if (pc_stall !== 1'b0) begin errors++; $display("FAIL full_flush_stall: got %b want 0", pc_stall); end
        vectors++;
        if (id_valid !== 1'b0) begin errors++; $display("FAIL full_flush_valid: got %b want 0", id_valid); end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) sb.push_back(32'h100 + 32'(i * 4));
        id_ready = 1'b1;
        cyc = 0;
        while (sb.size() > 0 && cyc < 20) begin
            if (id_valid && id_ready) begin
                vectors++;
                exp = sb.pop_front();
                if (id_pc !== exp || id_instr !== (exp ^ MASK))
                    begin errors++; $display("FAIL full_pop: got %h/%h want %h/%h", id_pc, id_instr, exp, exp ^ MASK); end
            end
            @(negedge clk); cyc++;
        end
        vectors++;
        if (sb.size() != 0) begin errors++; $display("FAIL full_timeout: %0d entries never delivered, want 0", sb.size()); end
    endtask

    task automatic test_flush_pop();
        int cyc;
        logic [31:0] exp;
        do_reset();
        id_ready = 1'b1;
        for (int i = 0; i < 3; i++) sb.push_back(32'(i * 4));
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (id_valid !== 1'b1) begin errors++; $display("FAIL fp_pre_valid: k %0d got %b want 1", k, id_valid); end
            else begin
                exp = sb.pop_front();
                if (id_pc !== exp || id_instr !== (exp ^ MASK))
                    begin errors++; $display("FAIL fp_pre_pop: got %h/%h want %h/%h", id_pc, id_instr, exp, exp ^ MASK); end
            end
            if (k == 2) begin br_ctrl = 1'b1; br_addr = 32'h100; end
            @(negedge clk);
        end
        br_ctrl = 1'b0;
        for (int i = 0; i < 4; i++) sb.push_back(32'h100 + 32'(i * 4));
        cyc = 1;
        while (sb.size() > 0 && cyc < 20) begin
            if (cyc <= 3) begin
                vectors++;
                if (id_valid !== 1'(cyc == 3)) begin errors++; $display("FAIL fp_valid: t+%0d got %b want %b", cyc, id_valid, cyc == 3); end
            end
            if (id_valid && id_ready) begin
                vectors++;
                exp = sb.pop_front();
                if (id_pc !== exp || id_instr !== (exp ^ MASK))
                    begin errors++; $display("FAIL fp_pop: got %h/%h want %h/%h", id_pc, id_instr, exp, exp ^ MASK); end
            end
            @(negedge clk); cyc++;
        end
        vectors++;
        if (sb.size() != 0) begin errors++; $display("FAIL fp_timeout: %0d entries never delivered, want 0", sb.size()); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        logic [31:0] exp;
        do_reset();
        repeat (4) @(negedge clk);
        vectors++;
        if (id_valid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid: got %b want 1", id_valid); end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 0) #1;
            else @(negedge clk);
            vectors++;
            if (id_valid !== 1'b0 || imem_en !== 1'b0 || pc_stall !== 1'b0)
                begin errors++; $display("FAIL rm_in_reset: k %0d valid/en/stall=%b%b%b want 000", k, id_valid, imem_en, pc_stall); end
        end
        rst = 1'b1; id_ready = 1'b1;
        for (int i = 0; i < 8; i++) sb.push_back(32'(i * 4));
        cyc = 0;
        while (sb.size() > 0 && cyc < 30) begin
            vectors++;
            if (id_valid !== 1'(cyc >= 2)) begin errors++; $display("FAIL rm_valid: cyc %0d got %b want %b", cyc, id_valid, cyc >= 2); end
            if (id_valid && id_ready) begin
                vectors++;
                exp = sb.pop_front();
                if (id_pc !== exp || id_instr !== (exp ^ MASK))
                    begin errors++; $display("FAIL rm_pop: got %h/%h want %h/%h", id_pc, id_instr, exp, exp ^ MASK); end
            end
            @(negedge clk); cyc++;
        end
        vectors++;
        if (sb.size() != 0) begin errors++; $display("FAIL rm_timeout: %0d entries never delivered, want 0", sb.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_fill_stall();
        test_flush_inflight();
        test_flush_full();
        test_flush_pop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
